branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 149 ++++++++++++++
 tb/tb_branch_resolve.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch resolution unit: decodes a conditional branch against the comparator
// result, issues a one-cycle fetch redirect and holds flush for FLUSH_CYCLES cycles.
module branch_resolve #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // Handshake: a branch is accepted on a rising edge where br_valid && br_ready.
  // br_valid is not held or buffered by this block; anything presented while
  // br_ready=0 is dropped, and the source owns any retry.
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_funct3,
  input  logic [31:0]      br_pc,
  input  logic [31:0]      br_imm,
  output logic             unsigned_cmp,
  input  logic             breq,
  input  logic             brlt,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             illegal,
  output logic             misalign,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             dbg_state
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      flush_cnt_q, flush_cnt_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [31:0]     redirect_pc_q, redirect_pc_d;
  logic            illegal_q, illegal_d;
  logic            misalign_q, misalign_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic        accept;
  logic        illegal_f3;
  logic        cond_raw;
  logic        taken;
  logic [31:0] target;
  logic        aligned;
  logic        do_redirect;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  assign unsigned_cmp = br_funct3[1];

  // Branch decode: funct3[2:1] picks the comparator flag, funct3[0] inverts it.
  always_comb begin
    accept     = br_valid && br_ready;
    illegal_f3 = (br_funct3[2:1] == 2'b01);
    cond_raw   = 1'b0;
    case (br_funct3[2:1])
      2'b00:   cond_raw = breq;
      2'b10:   cond_raw = brlt;
      2'b11:   cond_raw = brlt;
      default: cond_raw = 1'b0;
    endcase
    taken       = accept && !illegal_f3 && (cond_raw ^ br_funct3[0]);
    target      = br_pc + br_imm;
    aligned     = (target[1:0] == 2'b00);
    do_redirect = taken && aligned;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // FSM: next state. The counter holds the number of flush cycles still to
  // follow the current one, so FLUSH lasts exactly FLUSH_CYCLES cycles.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (do_redirect) begin
          state_d     = S_FLUSH;
          flush_cnt_d = FLUSH_LAST;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        flush_cnt_d = 4'd0;
      end
    endcase
  end

  // FSM: outputs, decoded from state so reset drops flush immediately
  always_comb begin
    br_ready  = (state_q == S_IDLE);
    flush     = (state_q == S_FLUSH);
    dbg_state = state_q;
  end

  // Registered result pulses and the saturating redirect counter
  always_comb begin
    redirect_valid_d = do_redirect;
    redirect_pc_d    = do_redirect ? target : redirect_pc_q;
    illegal_d        = accept && illegal_f3;
    misalign_d       = taken && !aligned;
    taken_cnt_d      = taken_cnt_q;
    if (do_redirect && (taken_cnt_q != {CNT_W{1'b1}})) begin
      taken_cnt_d = taken_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      illegal_q        <= 1'b0;
      misalign_q       <= 1'b0;
      taken_cnt_q      <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      illegal_q        <= illegal_d;
      misalign_q       <= misalign_d;
      taken_cnt_q      <= taken_cnt_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign illegal        = illegal_q;
  assign misalign       = misalign_q;
  assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: a default instance plus a CNT_W=4
// instance on the same stimulus for the saturation case.
module tb_branch_resolve;

  logic        clk;
  logic        rst_n;
  logic        br_valid;
  logic [2:0]  br_funct3;
  logic [31:0] br_pc;
  logic [31:0] br_imm;
  logic        breq;
  logic        brlt;

  logic        br_ready, unsigned_cmp, redirect_valid, flush, illegal, misalign, dbg_state;
  logic [31:0] redirect_pc;
  logic [15:0] taken_cnt;

  logic        s_br_ready, s_unsigned_cmp, s_redirect_valid, s_flush, s_illegal, s_misalign, s_dbg_state;
  logic [31:0] s_redirect_pc;
  logic [3:0]  s_taken_cnt;

  int n_checks;
  int n_errors;

  branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_funct3(br_funct3), .br_pc(br_pc), .br_imm(br_imm),
    .unsigned_cmp(unsigned_cmp), .breq(breq), .brlt(brlt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .illegal(illegal), .misalign(misalign), .taken_cnt(taken_cnt),
    .dbg_state(dbg_state)
  );

  branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(s_br_ready),
    .br_funct3(br_funct3), .br_pc(br_pc), .br_imm(br_imm),
    .unsigned_cmp(s_unsigned_cmp), .breq(breq), .brlt(brlt),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .flush(s_flush),
    .illegal(s_illegal), .misalign(s_misalign), .taken_cnt(s_taken_cnt),
    .dbg_state(s_dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one branch for one cycle; returns 1 unit into cycle N+1
  task automatic present(input logic [2:0] f3, input logic eq, input logic lt,
                         input logic [31:0] pc, input logic [31:0] imm);
    br_valid  = 1'b1;
    br_funct3 = f3;
    breq      = eq;
    brlt      = lt;
    br_pc     = pc;
    br_imm    = imm;
    step();
    br_valid  = 1'b0;
    breq      = 1'b0;
    brlt      = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    br_valid  = 1'b0;
    br_funct3 = 3'b000;
    br_pc     = 32'd0;
    br_imm    = 32'd0;
    breq      = 1'b0;
    brlt      = 1'b0;

    // Reset state
    #12;
    check("rst_ready", {31'd0, br_ready}, 32'd1);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_redir", {31'd0, redirect_valid}, 32'd0);
    check("rst_pc", redirect_pc, 32'd0);
    check("rst_cnt", {16'd0, taken_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", {31'd0, br_ready}, 32'd1);

    // BEQ taken: pc 0x100 + 0x20
    present(3'b000, 1'b1, 1'b0, 32'h100, 32'h20);
    check("beq_n1_redir", {31'd0, redirect_valid}, 32'd1);
    check("beq_n1_pc", redirect_pc, 32'h120);
    check("beq_n1_flush", {31'd0, flush}, 32'd1);
    check("beq_n1_ready", {31'd0, br_ready}, 32'd0);
    step();
    check("beq_n2_redir", {31'd0, redirect_valid}, 32'd0);
    check("beq_n2_flush", {31'd0, flush}, 32'd1);
    check("beq_n2_pc_hold", redirect_pc, 32'h120);
    step();
    check("beq_n3_ready", {31'd0, br_ready}, 32'd1);
    check("beq_n3_flush", {31'd0, flush}, 32'd0);
    check("beq_cnt", {16'd0, taken_cnt}, 32'd1);

    // BLTU not taken, back to back
    br_funct3 = 3'b110;
    #1;
    check("bltu_unsigned", {31'd0, unsigned_cmp}, 32'd1);
    br_funct3 = 3'b101;
    #1;
    check("bge_signed", {31'd0, unsigned_cmp}, 32'd0);
    @(posedge clk);
    #1;
    present(3'b110, 1'b0, 1'b0, 32'h200, 32'h40);
    check("bltu1_ready", {31'd0, br_ready}, 32'd1);
    check("bltu1_redir", {31'd0, redirect_valid}, 32'd0);
    present(3'b110, 1'b0, 1'b0, 32'h204, 32'h40);
    check("bltu2_ready", {31'd0, br_ready}, 32'd1);
    check("bltu2_redir", {31'd0, redirect_valid}, 32'd0);
    check("bltu2_flush", {31'd0, flush}, 32'd0);
    check("bltu_cnt", {16'd0, taken_cnt}, 32'd1);

    // BGE taken with backward wrap; a branch offered during FLUSH is dropped
    present(3'b101, 1'b0, 1'b0, 32'h4, 32'hFFFF_FFF8);
    check("wrap_redir", {31'd0, redirect_valid}, 32'd1);
    check("wrap_pc", redirect_pc, 32'hFFFF_FFFC);
    br_valid  = 1'b1;
    br_funct3 = 3'b000;
    breq      = 1'b1;
    br_pc     = 32'h300;
    br_imm    = 32'h10;
    step();
    step();
    br_valid = 1'b0;
    breq     = 1'b0;
    check("ignore_ready", {31'd0, br_ready}, 32'd1);
    step();
    check("ignore_redir", {31'd0, redirect_valid}, 32'd0);
    check("ignore_flush", {31'd0, flush}, 32'd0);
    check("ignore_cnt", {16'd0, taken_cnt}, 32'd2);

    // Reserved funct3
    present(3'b010, 1'b1, 1'b1, 32'h100, 32'h20);
    check("ill_pulse", {31'd0, illegal}, 32'd1);
    check("ill_redir", {31'd0, redirect_valid}, 32'd0);
    check("ill_flush", {31'd0, flush}, 32'd0);
    check("ill_mis", {31'd0, misalign}, 32'd0);
    step();
    check("ill_end", {31'd0, illegal}, 32'd0);

    // BNE taken to a misaligned target
    present(3'b001, 1'b0, 1'b0, 32'h100, 32'h2);
    check("mis_pulse", {31'd0, misalign}, 32'd1);
    check("mis_redir", {31'd0, redirect_valid}, 32'd0);
    check("mis_flush", {31'd0, flush}, 32'd0);
    check("mis_ready", {31'd0, br_ready}, 32'd1);
    check("mis_ill", {31'd0, illegal}, 32'd0);
    check("mis_pc_hold", redirect_pc, 32'hFFFF_FFFC);
    step();
    check("mis_end", {31'd0, misalign}, 32'd0);
    check("mis_cnt", {16'd0, taken_cnt}, 32'd2);

    // Reset asserted in N+1 of a taken branch
    present(3'b100, 1'b0, 1'b1, 32'h1000, 32'h8);
    check("rmf_flush_before", {31'd0, flush}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmf_flush", {31'd0, flush}, 32'd0);
    check("rmf_cnt", {16'd0, taken_cnt}, 32'd0);
    check("rmf_ready", {31'd0, br_ready}, 32'd1);
    check("rmf_redir", {31'd0, redirect_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rmf_post_ready", {31'd0, br_ready}, 32'd1);
    check("rmf_post_flush", {31'd0, flush}, 32'd0);
    step();
    check("rmf_post_redir", {31'd0, redirect_valid}, 32'd0);

    // Saturation: 17 taken BLTs into both instances
    for (int i = 0; i < 17; i++) begin
      present(3'b100, 1'b0, 1'b1, 32'h40 * i, 32'h100);
      step();
      step();
      if (i == 14) check("sat_at15", {28'd0, s_taken_cnt}, 32'hF);
    end
    check("sat_cnt", {28'd0, s_taken_cnt}, 32'hF);
    check("wide_cnt", {16'd0, taken_cnt}, 32'd17);
    check("sat_last_pc", redirect_pc, 32'h500);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
